sync_fifo_lvl: RTL

Parametrised single-clock FIFO that extends the basic synchronous FIFO with a live fill level, run-time almost-full/almost-empty thresholds, a synchronous flush, and an optional registered read port. It sits between producer and consumer blocks in one clock domain where flow control needs early warning, not just full/empty. Memory is an internal register array of 2^ADDR_WIDTH entries.

---
 rtl/sync_fifo_lvl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_lvl.sv
// ============================================================================
// Module   : sync_fifo_lvl
// Brief    : Single-clock FIFO with fill level, run-time almost-full/empty
//            thresholds, synchronous flush and optional registered read port.
//            Optional sticky overflow/underflow flags: SYNC_FIFO_LVL_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_lvl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wfull_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rempty_o,
    input  logic [ADDR_WIDTH:0]   af_thr_i,
    input  logic [ADDR_WIDTH:0]   ae_thr_i,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic                  ovf_o,
    output logic                  udf_o,
    input  logic                  err_clr_i
);

    localparam int                c_NUM_ENTRIES = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [c_NUM_ENTRIES];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   w_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Extra wrap bit makes the modular difference span 0..DEPTH.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == c_DEPTH);
    assign w_push  = wr_en_i & ~w_full  & ~flush_i;
    assign w_pop   = rd_en_i & ~w_empty & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wdata_i;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_valid;
            logic [DATA_WIDTH-1:0] r_rdata;
            logic [ADDR_WIDTH-1:0] w_next_addr;

            assign w_next_addr = r_rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);

            // Head copy stays counted in level until popped. When the last
            // stored entry is popped, a concurrent push is forwarded directly.
            always_ff @(posedge clk_i) begin
                if (reset_i || flush_i) begin
                    r_valid <= 1'b0;
                end else if (w_pop) begin
                    if (w_level > (ADDR_WIDTH+1)'(1)) begin
                        r_rdata <= r_mem[w_next_addr];
                        r_valid <= 1'b1;
                    end else begin
                        r_rdata <= wdata_i;
                        r_valid <= w_push;
                    end
                end else if (!r_valid && (w_level != '0)) begin
                    r_rdata <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                    r_valid <= 1'b1;
                end
            end

            assign w_empty = ~r_valid;
            assign rdata_o = r_rdata;
        end else begin : g_out_comb
            assign w_empty = (w_level == '0);
            assign rdata_o = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    endgenerate

    assign level_o  = w_level;
    assign wfull_o  = w_full;
    assign rempty_o = w_empty;
    assign afull_o  = (w_level >= af_thr_i);
    assign aempty_o = (w_level <= ae_thr_i);

`ifdef SYNC_FIFO_LVL_ERR_EN
    logic r_ovf;
    logic r_udf;

    // A new error event takes priority over a clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en_i && w_full && !flush_i) r_ovf <= 1'b1;
            else if (err_clr_i)                r_ovf <= 1'b0;
            if (rd_en_i && w_empty && !flush_i) r_udf <= 1'b1;
            else if (err_clr_i)                 r_udf <= 1'b0;
        end
    end

    assign ovf_o = r_ovf;
    assign udf_o = r_udf;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr_i;
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

`default_nettype wire
